// File: rtl/universal_shift_counter_if.sv
`default_nettype none
// ============================================================================
// Module   : universal_shift_counter_if
// Brief    : Control/data bundle for universal_shift_counter (master drives
//            controls and data, slave returns register state and flags).
// Revision : 1.0
// ============================================================================
interface universal_shift_counter_if #(
   parameter int WIDTH = 4
);
   logic             clr;
   logic             en;
   logic [2:0]       mode;
   logic [WIDTH-1:0] d;
   logic             sin_r;
   logic             sin_l;
   logic [WIDTH-1:0] q;
   logic [WIDTH-1:0] q_bar;
   logic             sout_r;
   logic             sout_l;
   logic             tc;

   modport master (
      output clr, en, mode, d, sin_r, sin_l,
      input  q, q_bar, sout_r, sout_l, tc
   );

   modport slave (
      input  clr, en, mode, d, sin_r, sin_l,
      output q, q_bar, sout_r, sout_l, tc
   );
endinterface
`default_nettype wire

// File: rtl/universal_shift_counter.sv
`default_nettype none
// ============================================================================
// Module   : universal_shift_counter
// Brief    : WIDTH-bit register with hold/shift/load/rotate/count modes,
//            synchronous clear, clock enable and terminal-count flag.
// Revision : 1.0
// ============================================================================
module universal_shift_counter #(
   parameter int WIDTH = 4
) (
   input  wire logic                clk,
   input  wire logic                reset,
   universal_shift_counter_if.slave bus
);
   localparam logic [2:0]       c_MODE_HOLD   = 3'b000;
   localparam logic [2:0]       c_MODE_SHR    = 3'b001;
   localparam logic [2:0]       c_MODE_SHL    = 3'b010;
   localparam logic [2:0]       c_MODE_LOAD   = 3'b011;
   localparam logic [2:0]       c_MODE_ROR    = 3'b100;
   localparam logic [2:0]       c_MODE_ROL    = 3'b101;
   localparam logic [2:0]       c_MODE_UP     = 3'b110;
   localparam logic [2:0]       c_MODE_DOWN   = 3'b111;
   localparam logic [WIDTH-1:0] c_ONE         = WIDTH'(1);
   localparam logic [WIDTH-1:0] c_ALL_ONES    = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0] c_ZERO        = {WIDTH{1'b0}};

   logic [WIDTH-1:0] r_q;
   logic [WIDTH-1:0] w_q_next;
   logic             w_tc;

   always_comb begin
      w_q_next = r_q;
      case (bus.mode)
         c_MODE_HOLD: w_q_next = r_q;
         c_MODE_SHR:  w_q_next = {bus.sin_r, r_q[WIDTH-1:1]};
         c_MODE_SHL:  w_q_next = {r_q[WIDTH-2:0], bus.sin_l};
         c_MODE_LOAD: w_q_next = bus.d;
         c_MODE_ROR:  w_q_next = {r_q[0], r_q[WIDTH-1:1]};
         c_MODE_ROL:  w_q_next = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
         c_MODE_UP:   w_q_next = r_q + c_ONE;
         c_MODE_DOWN: w_q_next = r_q - c_ONE;
         default:     w_q_next = r_q;
      endcase
   end

   // Priority: async reset, then clr (even with en low), then en, then mode.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_q <= c_ZERO;
      end else if (bus.clr) begin
         r_q <= c_ZERO;
      end else if (bus.en) begin
         r_q <= w_q_next;
      end
   end

   // Gated by reset so that mode 111 with q=0 cannot flag during reset.
   always_comb begin
      w_tc = reset & bus.en & ~bus.clr &
             (((bus.mode == c_MODE_UP)   && (r_q == c_ALL_ONES)) ||
              ((bus.mode == c_MODE_DOWN) && (r_q == c_ZERO)));
   end

   assign bus.q      = r_q;
   assign bus.q_bar  = ~r_q;
   assign bus.sout_r = r_q[0];
   assign bus.sout_l = r_q[WIDTH-1];
   assign bus.tc     = w_tc;
endmodule
`default_nettype wire

// File: tb/tb_universal_shift_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_universal_shift_counter
// Brief    : Directed vector table, corner sequences and randomized run
//            against an arithmetic reference model, for WIDTH=4 and WIDTH=8.
// Revision : 1.0
// ============================================================================
module tb_universal_shift_counter;
   logic clk;
   logic reset;
   int   n_checks;
   int   n_errors;

   universal_shift_counter_if #(.WIDTH(4)) u_if4 ();
   universal_shift_counter_if #(.WIDTH(8)) u_if8 ();

   universal_shift_counter #(.WIDTH(4)) u_dut4 (.clk(clk), .reset(reset), .bus(u_if4));
   universal_shift_counter #(.WIDTH(8)) u_dut8 (.clk(clk), .reset(reset), .bus(u_if8));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       clr;
      logic       en;
      logic [2:0] mode;
      logic [3:0] d;
      logic       sin_r;
      logic       sin_l;
      logic [3:0] exp_q;
      logic       exp_tc;
   } vec_t;

   vec_t vecs[$];

   function automatic void add(input logic clr, input logic en, input logic [2:0] mode,
                               input logic [3:0] d, input logic sr, input logic sl,
                               input logic [3:0] eq, input logic et);
      vec_t v;
      v.clr = clr; v.en = en; v.mode = mode; v.d = d;
      v.sin_r = sr; v.sin_l = sl; v.exp_q = eq; v.exp_tc = et;
      vecs.push_back(v);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference model: register treated as a number modulo 2^w.
   function automatic logic [31:0] ref_next(input int w, input logic [31:0] q,
                                            input logic clr, input logic en,
                                            input logic [2:0] mode, input logic [31:0] d,
                                            input logic sr, input logic sl);
      longint unsigned m;
      longint unsigned v;
      longint unsigned r;
      m = (64'd1 << w) - 1;
      v = 64'(q);
      if (clr) return 32'd0;
      if (!en) return q;
      case (mode)
         3'd1:    r = (v / 2) + (64'(sr) * (64'd1 << (w - 1)));
         3'd2:    r = (v * 2 + 64'(sl)) % (m + 1);
         3'd3:    r = 64'(d) & m;
         3'd4:    r = (v / 2) + ((v % 2) * (64'd1 << (w - 1)));
         3'd5:    r = (v * 2 + (v >> (w - 1))) % (m + 1);
         3'd6:    r = (v + 1) % (m + 1);
         3'd7:    r = (v + m) % (m + 1);
         default: r = v;
      endcase
      return 32'(r);
   endfunction

   function automatic logic ref_tc(input int w, input logic [31:0] q, input logic rst_n,
                                   input logic clr, input logic en, input logic [2:0] mode);
      longint unsigned m;
      m = (64'd1 << w) - 1;
      if (!rst_n || clr || !en) return 1'b0;
      if (mode == 3'd6) return (64'(q) == m);
      if (mode == 3'd7) return (q == 32'd0);
      return 1'b0;
   endfunction

   task automatic check_out(input string tag, input int w, input logic [31:0] q,
                            input logic [31:0] qb, input logic so_r, input logic so_l,
                            input logic t, input logic [31:0] eq, input logic et);
      logic [31:0] m;
      m = 32'((64'd1 << w) - 1);
      check({tag, ".q"}, q, eq);
      check({tag, ".q_bar"}, qb, ~eq & m);
      check({tag, ".sout_r"}, 32'(so_r), eq & 32'd1);
      check({tag, ".sout_l"}, 32'(so_l), (eq >> (w - 1)) & 32'd1);
      check({tag, ".tc"}, 32'(t), 32'(et));
   endtask

   task automatic drive4(input logic clr, input logic en, input logic [2:0] mode,
                         input logic [3:0] d, input logic sr, input logic sl);
      u_if4.clr = clr; u_if4.en = en; u_if4.mode = mode;
      u_if4.d = d; u_if4.sin_r = sr; u_if4.sin_l = sl;
   endtask

   task automatic drive8(input logic clr, input logic en, input logic [2:0] mode,
                         input logic [7:0] d, input logic sr, input logic sl);
      u_if8.clr = clr; u_if8.en = en; u_if8.mode = mode;
      u_if8.d = d; u_if8.sin_r = sr; u_if8.sin_l = sl;
   endtask

   task automatic chk4(input string tag, input logic [3:0] eq, input logic et);
      check_out(tag, 4, 32'(u_if4.q), 32'(u_if4.q_bar), u_if4.sout_r, u_if4.sout_l,
                u_if4.tc, 32'(eq), et);
   endtask

   task automatic chk8(input string tag, input logic [7:0] eq, input logic et);
      check_out(tag, 8, 32'(u_if8.q), 32'(u_if8.q_bar), u_if8.sout_r, u_if8.sout_l,
                u_if8.tc, 32'(eq), et);
   endtask

   initial begin
      logic [31:0] mq4;
      logic [31:0] mq8;
      logic        rc, re, rsr, rsl;
      logic [2:0]  rm;
      logic [3:0]  rd4;
      logic [7:0]  rd8;

      n_checks = 0;
      n_errors = 0;
      reset    = 1'b0;
      drive4(1'b0, 1'b1, 3'b111, 4'h0, 1'b0, 1'b0);
      drive8(1'b0, 1'b1, 3'b111, 8'h00, 1'b0, 1'b0);

      // Reset state: mode 111 with q=0 must not raise tc while reset is low.
      repeat (2) @(posedge clk);
      #1;
      chk4("rst4", 4'h0, 1'b0);
      chk8("rst8", 8'h00, 1'b0);
      @(negedge clk);
      reset = 1'b1;
      drive8(1'b0, 1'b0, 3'b000, 8'h00, 1'b0, 1'b0);

      // Async reset mid-run from q=1011.
      drive4(1'b0, 1'b1, 3'b011, 4'hB, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      chk4("pre_rst", 4'hB, 1'b0);
      drive4(1'b0, 1'b1, 3'b111, 4'h0, 1'b0, 1'b0);
      #2;
      reset = 1'b0;
      #1;
      chk4("mid_rst", 4'h0, 1'b0);
      @(negedge clk);
      reset = 1'b1;

      // Directed table (WIDTH=4), starting from q=0.
      add(0, 1, 3'b011, 4'hA, 0, 0, 4'hA, 0);
      add(0, 1, 3'b001, 4'h0, 1, 0, 4'hD, 0);
      add(0, 1, 3'b001, 4'h0, 1, 0, 4'hE, 0);
      add(0, 1, 3'b001, 4'h0, 1, 0, 4'hF, 0);
      add(0, 1, 3'b010, 4'h0, 1, 0, 4'hE, 0);
      add(0, 1, 3'b010, 4'h0, 1, 0, 4'hC, 0);
      add(0, 1, 3'b011, 4'h9, 0, 0, 4'h9, 0);
      add(0, 1, 3'b100, 4'hF, 1, 1, 4'hC, 0);
      add(0, 1, 3'b101, 4'hF, 1, 1, 4'h9, 0);
      add(0, 1, 3'b101, 4'hF, 0, 0, 4'h3, 0);
      add(0, 1, 3'b011, 4'hE, 0, 0, 4'hE, 0);
      add(0, 1, 3'b110, 4'h0, 0, 0, 4'hF, 1);
      add(0, 1, 3'b110, 4'h0, 0, 0, 4'h0, 0);
      add(0, 1, 3'b011, 4'h1, 0, 0, 4'h1, 0);
      add(0, 1, 3'b111, 4'h0, 0, 0, 4'h0, 1);
      add(0, 1, 3'b111, 4'h0, 0, 0, 4'hF, 0);
      add(0, 1, 3'b011, 4'h6, 0, 0, 4'h6, 0);
      for (int i = 0; i < 5; i++) add(0, 0, 3'b110, 4'h0, 1, 1, 4'h6, 0);
      add(1, 1, 3'b011, 4'hF, 0, 0, 4'h0, 0);
      add(0, 1, 3'b011, 4'h5, 0, 0, 4'h5, 0);
      add(1, 0, 3'b111, 4'hF, 0, 0, 4'h0, 0);
      add(0, 1, 3'b000, 4'hF, 1, 1, 4'h0, 0);
      add(0, 1, 3'b011, 4'h3, 0, 0, 4'h3, 0);
      add(0, 1, 3'b000, 4'hC, 1, 1, 4'h3, 0);
      add(0, 1, 3'b001, 4'hF, 0, 1, 4'h1, 0);

      foreach (vecs[i]) begin
         drive4(vecs[i].clr, vecs[i].en, vecs[i].mode, vecs[i].d, vecs[i].sin_r, vecs[i].sin_l);
         @(posedge clk);
         #1;
         chk4($sformatf("vec%0d", i), vecs[i].exp_q, vecs[i].exp_tc);
      end

      // WIDTH=8 count-up wrap through 0xFF.
      drive8(1'b0, 1'b1, 3'b011, 8'hFE, 1'b0, 1'b0);
      @(posedge clk); #1;
      chk8("w8_load", 8'hFE, 1'b0);
      drive8(1'b0, 1'b1, 3'b110, 8'h00, 1'b0, 1'b0);
      @(posedge clk); #1;
      chk8("w8_ff", 8'hFF, 1'b1);
      @(posedge clk); #1;
      chk8("w8_wrap", 8'h00, 1'b0);

      // Randomized run against the model, with occasional async reset pulses.
      mq4 = 32'(u_if4.q);
      mq8 = 32'h0;
      for (int n = 0; n < 400; n++) begin
         rc  = ($urandom_range(0, 9) == 0);
         re  = ($urandom_range(0, 3) != 0);
         rm  = 3'($urandom_range(0, 7));
         rd4 = 4'($urandom);
         rd8 = 8'($urandom);
         rsr = 1'($urandom);
         rsl = 1'($urandom);
         drive4(rc, re, rm, rd4, rsr, rsl);
         drive8(rc, re, rm, rd8, rsr, rsl);
         if ($urandom_range(0, 29) == 0) begin
            reset = 1'b0;
            #1;
            mq4 = 32'd0;
            mq8 = 32'd0;
            chk4("rnd_rst4", 4'(mq4), 1'b0);
            chk8("rnd_rst8", 8'(mq8), 1'b0);
            #2;
            reset = 1'b1;
         end
         mq4 = ref_next(4, mq4, rc, re, rm, 32'(rd4), rsr, rsl);
         mq8 = ref_next(8, mq8, rc, re, rm, 32'(rd8), rsr, rsl);
         @(posedge clk);
         #1;
         chk4($sformatf("rnd4_%0d", n), 4'(mq4), ref_tc(4, mq4, reset, rc, re, rm));
         chk8($sformatf("rnd8_%0d", n), 8'(mq8), ref_tc(8, mq8, reset, rc, re, rm));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/universal_shift_counter.md
Name: universal_shift_counter

Overview:
- Parametrised WIDTH-bit register built from rising-edge D flip-flop cells.
- Selectable modes: hold, shift right/left, parallel load, rotate right/left, count up/down.
- Supports synchronous clear, clock enable, serial in/out and terminal-count flag.
- Generic state element for lab datapaths (counters, serial converters, sequence generators); supersedes single-bit flip-flop with synchronous reset.

Parameters:
- WIDTH, 4, register width in bits; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous active-low reset; q cleared immediately while low
- clr  input  1  synchronous clear, active-high
- en  input  1  clock enable, active-high
- mode  input  3  operation select (see Behaviour)
- d  input  WIDTH  parallel load data
- sin_r  input  1  serial input entering MSB on shift right
- sin_l  input  1  serial input entering LSB on shift left
- q  output  WIDTH  register state
- q_bar  output  WIDTH  bitwise complement of q
- sout_r  output  1  equals q[0]
- sout_l  output  1  equals q[WIDTH-1]
- tc  output  1  terminal count, combinational

Behaviour:
- Clock, reset and polarity (decided): one clock, clk. Reset is asynchronous and active-low, port name reset.
- Priority, highest first:
  - reset=0: q=0 asynchronously, independent of clk.
  - clr=1 at clk rise: q<=0.
  - en=0 at clk rise: q holds.
  - Otherwise mode applies at clk rise.
- Mode encoding:
  - 000 hold: q<=q.
  - 001 shift right: q<={sin_r, q[WIDTH-1:1]}.
  - 010 shift left: q<={q[WIDTH-2:0], sin_l}.
  - 011 parallel load: q<=d.
  - 100 rotate right: q<={q[0], q[WIDTH-1:1]}.
  - 101 rotate left: q<={q[WIDTH-2:0], q[WIDTH-1]}.
  - 110 count up: q<=q+1 mod 2^WIDTH; all-ones wraps to 0.
  - 111 count down: q<=q-1 mod 2^WIDTH; 0 wraps to all-ones.
- Latency: one clk edge from input to q. q_bar, sout_r, sout_l and tc follow q combinationally.
- tc = en & ~clr & ((mode==110 & q==all-ones) | (mode==111 & q==0)). tc=0 in all other modes. Intended for cascading en of a next stage.
- Reset values while reset=0: q=0, q_bar=all-ones, sout_r=0, sout_l=0, tc=0 (mode 111 with q=0 would assert tc; reset also forces tc=0).
- Reset mid-operation: q clears within the same cycle. On reset release, the first active clk edge applies normal priority. Release coincident with a clk edge is not guaranteed to capture.
- Simultaneous clr=1 and en=1: clr wins. clr=1 with en=0: clr still clears (clr outranks en).
- Serial inputs are ignored in every mode except 001 and 010. d is ignored except in mode 011.
- No X propagation from unused inputs.

Test Plan:
- WIDTH=4. reset=0 mid-run with q=1011 → q=0000, q_bar=1111 before next edge. Release, mode=011, d=1010, en=1 → q=1010 after one edge.
- q=1010, mode=001, sin_r=1, 3 edges → q=1101, 1110, 1111. Then mode=010, sin_l=0, 2 edges → q=1110, 1100. sout_l/sout_r track q[3]/q[0].
- q=1001: mode=100 one edge → 1100. Then mode=101 two edges → 1001, 0011.
- mode=110 from q=1110 → 1111 (tc=1 while at 1111) → 0000 (tc=0). mode=111 from 0001 → 0000 (tc=1) → 1111.
- q=0110, en=0, mode=110, 5 edges → q stays 0110, tc=0. Then clr=1 with en=1, mode=011, d=1111 → q=0000.
- WIDTH=8 instance, count up from 0xFE → 0xFF (tc=1) → 0x00. Confirm no width truncation.
